// File: rtl/gbuff_arbiter.sv
// Round-robin arbiter sharing one global-buffer port among NREQ requesters.
// Bursts hold the port until last; a watchdog reclaims it from stalled owners.
module gbuff_arbiter #(
    parameter int NREQ      = 3,
    parameter int ROW_SIZE  = 5,
    parameter int WORD_SIZE = 256,
    parameter int TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           last,
    input  logic [NREQ-1:0]           wr_en,
    input  logic [NREQ*ROW_SIZE-1:0]  index,
    input  logic [NREQ*WORD_SIZE-1:0] wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic                      rvalid,
    output logic [$clog2(NREQ)-1:0]   rid,
    output logic [WORD_SIZE-1:0]      rdata,
    output logic                      to_err,
    output logic                      buf_wr_en,
    output logic [ROW_SIZE-1:0]       buf_index,
    output logic [WORD_SIZE-1:0]      buf_data_in,
    input  logic [WORD_SIZE-1:0]      buf_data_out
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {
        FREE,
        OWNED
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      stall_q, stall_d;
    logic            to_err_d;

    logic            beat;
    logic            last_beat;
    logic            rd_beat;
    logic            win_found;
    logic [IW-1:0]   win;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (int'(x) == NREQ - 1) ? '0 : x + IW'(1);
    endfunction

    assign beat      = (state_q == OWNED) && req[own_q];
    assign last_beat = beat && last[own_q];
    assign rd_beat   = beat && !wr_en[own_q];
    assign ack       = gnt_q & req;
    assign gnt       = gnt_q;

    // First pending requester at or after ptr, with wrap-around.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        j         = 0;
        jj        = '0;
        win_found = 1'b0;
        win       = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IW'(j);
            if (!win_found && req[jj]) begin
                win_found = 1'b1;
                win       = jj;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        own_d    = own_q;
        ptr_d    = ptr_q;
        stall_d  = stall_q;
        to_err_d = 1'b0;
        unique case (state_q)
            FREE: begin
                if (win_found) begin
                    state_d = OWNED;
                    gnt_d   = NREQ'(1) << win;
                    own_d   = win;
                    ptr_d   = wrap_inc(win);
                end
                stall_d = '0;
            end
            OWNED: begin
                if (last_beat) begin
                    stall_d = '0;
                    if (win_found) begin
                        gnt_d = NREQ'(1) << win;
                        own_d = win;
                        ptr_d = wrap_inc(win);
                    end else begin
                        state_d = FREE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    stall_d = '0;
                end else if (stall_q == 8'(TIMEOUT - 1)) begin
                    // This stalled cycle is the TIMEOUT-th in a row.
                    state_d  = FREE;
                    gnt_d    = '0;
                    ptr_d    = wrap_inc(own_q);
                    stall_d  = '0;
                    to_err_d = 1'b1;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            default: begin
                state_d = FREE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        buf_wr_en   = 1'b0;
        buf_index   = '0;
        buf_data_in = '0;
        if (beat) begin
            buf_wr_en   = wr_en[own_q];
            buf_index   = index[own_q*ROW_SIZE +: ROW_SIZE];
            buf_data_in = wdata[own_q*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= FREE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            stall_q <= '0;
            to_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            to_err  <= to_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rvalid <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_beat;
            if (rd_beat) begin
                rid   <= own_q;
                rdata <= buf_data_out;
            end
        end
    end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Scoreboard bench for gbuff_arbiter: directed bursts then random traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_gbuff_arbiter;

    localparam int NREQ = 3;
    localparam int RS   = 5;
    localparam int WS   = 256;
    localparam int TO   = 3;
    localparam int NROW = 1 << RS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req, last, wr_en;
    logic [NREQ*RS-1:0]   index;
    logic [NREQ*WS-1:0]   wdata;
    logic [NREQ-1:0]      gnt, ack;
    logic                 rvalid;
    logic [1:0]           rid;
    logic [WS-1:0]        rdata;
    logic                 to_err;
    logic                 buf_wr_en;
    logic [RS-1:0]        buf_index;
    logic [WS-1:0]        buf_data_in;
    logic [WS-1:0]        buf_data_out;

    logic                 r_req  [NREQ];
    logic                 r_last [NREQ];
    logic                 r_wr   [NREQ];
    logic [RS-1:0]        r_idx  [NREQ];
    logic [WS-1:0]        r_wd   [NREQ];

    logic                 init_mem;
    logic [WS-1:0]        mem     [NROW];
    logic [WS-1:0]        ref_mem [NROW];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int            id;
        logic [WS-1:0] d;
        int            c;
    } rd_t;
    rd_t rq[$];

    gbuff_arbiter #(
        .NREQ(NREQ), .ROW_SIZE(RS), .WORD_SIZE(WS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .wr_en(wr_en),
        .index(index), .wdata(wdata), .gnt(gnt), .ack(ack),
        .rvalid(rvalid), .rid(rid), .rdata(rdata), .to_err(to_err),
        .buf_wr_en(buf_wr_en), .buf_index(buf_index),
        .buf_data_in(buf_data_in), .buf_data_out(buf_data_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        req   = '0;
        last  = '0;
        wr_en = '0;
        index = '0;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = r_req[i];
            last[i]             = r_last[i];
            wr_en[i]            = r_wr[i];
            index[i*RS +: RS]   = r_idx[i];
            wdata[i*WS +: WS]   = r_wd[i];
        end
    end

    function automatic logic [WS-1:0] word_of(input int r);
        return {8{32'hC0DE0000 + 32'(r)}};
    endfunction

    // The buffer itself: combinational read, write on the clock edge.
    assign buf_data_out = mem[buf_index];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int r = 0; r < NROW; r++) mem[r] <= word_of(r);
        end else if (buf_wr_en) begin
            mem[buf_index] <= buf_data_in;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [WS-1:0] got,
                       input logic [WS-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    endtask

    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: owner (-1 = free), pointer, stall run length.
    int  m_own   = -1;
    int  m_ptr   = 0;
    int  m_stall = 0;
    bit  m_toerr = 1'b0;
    bit  m_valid = 1'b0;

    initial begin
        logic [NREQ-1:0] e_gnt, e_ack;
        logic            e_we;
        logic [RS-1:0]   e_idx;
        logic [WS-1:0]   e_din;
        bit              bt;
        int              w;
        forever begin
            @(negedge clk);
            e_gnt = '0;
            e_ack = '0;
            e_we  = 1'b0;
            e_idx = '0;
            e_din = '0;
            bt    = (m_own >= 0) && r_req[m_own];
            if (m_own >= 0) e_gnt[m_own] = 1'b1;
            if (bt) begin
                e_ack[m_own] = 1'b1;
                e_we  = r_wr[m_own];
                e_idx = r_idx[m_own];
                e_din = r_wd[m_own];
            end
            if (m_valid) begin
                chk("gnt", WS'(gnt), WS'(e_gnt));
                chk("to_err", WS'(to_err), WS'(m_toerr));
                chk("ack", WS'(ack), WS'(e_ack));
                chk("buf_wr_en", WS'(buf_wr_en), WS'(e_we));
                chk("buf_index", WS'(buf_index), WS'(e_idx));
                chk("buf_data_in", buf_data_in, e_din);
            end
            if (init_mem) begin
                for (int r = 0; r < NROW; r++) ref_mem[r] = word_of(r);
            end else if (bt) begin
                if (!r_wr[m_own] && !rst_n) rq.push_back('{m_own, ref_mem[e_idx], cyc});
                if (r_wr[m_own]) ref_mem[e_idx] = e_din;
            end
            m_toerr = 1'b0;
            if (rst_n) begin
                m_own   = -1;
                m_ptr   = 0;
                m_stall = 0;
                m_valid = 1'b1;
            end else if (m_own < 0 || (bt && r_last[m_own])) begin
                w       = pick(m_ptr, req);
                m_stall = 0;
                m_own   = w;
                if (w >= 0) m_ptr = (w + 1) % NREQ;
            end else if (bt) begin
                m_stall = 0;
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    m_ptr   = (m_own + 1) % NREQ;
                    m_own   = -1;
                    m_stall = 0;
                    m_toerr = 1'b1;
                end
            end
        end
    end

    // Monitor: pairs every rvalid with the oldest expected read.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (rvalid) begin
                    if (rq.size() == 0) begin
                        chk("rvalid_spurious", WS'(rvalid), WS'(0));
                    end else begin
                        e = rq.pop_front();
                        chk("rid", WS'(rid), WS'(e.id));
                        chk("rdata", rdata, e.d);
                        chk("rd_latency", WS'(cyc - e.c), WS'(1));
                    end
                end else if (rq.size() > 0 && rq[0].c < cyc) begin
                    e = rq.pop_front();
                    chk("rvalid_missing", WS'(rvalid), WS'(1));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic burst(input int i, input int n, input bit wr,
                         input int row0, input logic [WS-1:0] d0,
                         input bit do_last);
        int b     = 0;
        int tries = 0;
        bit acked;
        while (b < n && tries < 100) begin
            r_req[i]  = 1'b1;
            r_last[i] = do_last && (b == n - 1);
            r_wr[i]   = wr;
            r_idx[i]  = RS'(row0 + b);
            r_wd[i]   = d0 + WS'(b);
            @(negedge clk);
            acked = ack[i];
            @(posedge clk);
            #1;
            if (acked) b++;
            tries++;
        end
        chk("burst_done", WS'(b), WS'(n));
        r_req[i]  = 1'b0;
        r_last[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b1;
        step(1);
        rst_n = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            r_req[i]  = 1'b0;
            r_last[i] = 1'b0;
            r_wr[i]   = 1'b0;
            r_idx[i]  = '0;
            r_wd[i]   = '0;
        end
        rst_n    = 1'b1;
        init_mem = 1'b1;
        step(3);
        rst_n    = 1'b0;
        init_mem = 1'b0;

        burst(0, 4, 1'b1, 0, WS'(8'hA0), 1'b1);
        step(2);

        pulse_reset();
        fork
            burst(0, 2, 1'b1, 8, WS'(8'h10), 1'b1);
            burst(1, 2, 1'b1, 10, WS'(8'h20), 1'b1);
            burst(2, 2, 1'b1, 12, WS'(8'h30), 1'b1);
        join
        step(1);
        fork
            burst(0, 1, 1'b0, 8, '0, 1'b1);
            burst(2, 1, 1'b0, 12, '0, 1'b1);
        join
        step(2);

        burst(0, 2, 1'b1, 5, WS'(16'h5500), 1'b1);
        burst(1, 2, 1'b0, 5, '0, 1'b1);
        step(2);

        fork
            burst(2, 1, 1'b1, 7, WS'(8'h77), 1'b0);
            begin
                step(1);
                burst(0, 1, 1'b1, 9, WS'(8'h99), 1'b1);
            end
        join
        step(2);

        fork
            burst(0, 4, 1'b1, 16, WS'(8'hB0), 1'b1);
            begin
                step(1);
                r_req[1] = 1'b1;
                r_wr[1]  = 1'b1;
                r_idx[1] = RS'(20);
                r_wd[1]  = '1;
                step(4);
                r_req[1] = 1'b0;
            end
        join
        step(6);

        fork
            burst(0, 4, 1'b0, 5, '0, 1'b1);
            burst(1, 2, 1'b0, 6, '0, 1'b1);
            begin
                step(3);
                pulse_reset();
            end
        join
        step(3);

        repeat (2000) begin
            for (int i = 0; i < NREQ; i++) begin
                r_req[i]  = ($urandom_range(0, 9) < 6);
                r_last[i] = ($urandom_range(0, 2) == 0);
                r_wr[i]   = $urandom_range(0, 1) == 1;
                r_idx[i]  = RS'($urandom_range(0, NROW - 1));
                r_wd[i]   = {8{$urandom}};
            end
            rst_n = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            r_req[i]  = 1'b0;
            r_last[i] = 1'b0;
        end
        step(5);
        chk("rq_drained", WS'(rq.size()), WS'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gbuff_arbiter.md
# gbuff_arbiter

Round-robin arbiter that shares one global-buffer port between up to NREQ requesters: host loader, TPU operand fetch, TPU writeback and output drain. A requester holds the port for a whole burst, terminated by `last`. The arbiter muxes the winner's write-enable, index and data onto the buffer and returns read data tagged with the owner's ID one cycle later. A watchdog reclaims the port from a requester that stalls mid-burst.

## Interface
- NREQ, 3, number of requesters (2..4)
- ROW_SIZE, 5, buffer index width
- WORD_SIZE, 256, buffer word width
- TIMEOUT, 15, max consecutive stalled cycles inside a burst before forced release (1..255)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-high (1 = reset); name kept per codebase convention
- req  in  NREQ  per-requester beat request; bit i belongs to requester i
- last  in  NREQ  marks the final beat of requester i's burst; sampled only with req[i]
- wr_en  in  NREQ  1 = write beat, 0 = read beat
- index  in  NREQ*ROW_SIZE  packed row indices; slice i is requester i
- wdata  in  NREQ*WORD_SIZE  packed write data
- gnt  out  NREQ  registered one-hot owner; all-zero = port free
- ack  out  NREQ  combinational, gnt & req; beat accepted this cycle
- rvalid  out  1  read data valid, registered
- rid  out  clog2(NREQ)  owner of the read data on rdata
- rdata  out  WORD_SIZE  read data, registered copy of buf_data_out
- to_err  out  1  one-cycle pulse on watchdog release
- buf_wr_en  out  1  buffer write enable
- buf_index  out  ROW_SIZE  buffer row
- buf_data_in  out  WORD_SIZE  buffer write data
- buf_data_out  in  WORD_SIZE  buffer read data, combinational on buf_index

## Operation
- States: FREE (gnt == 0) and OWNED (gnt one-hot).
- Arbitration event: occurs in FREE, or in OWNED on the owner's last beat (ack[o] & last[o]).
  - The winner is the first requester with req high, searching from `ptr` upward with wrap-around.
  - At the clock edge, gnt takes the winner and ptr becomes (winner+1) mod NREQ.
  - If no request is pending, gnt becomes 0 and ptr is unchanged.
- Handover on a last beat:
  - The current owner competes too, but the search starts at ptr, which already points past it.
  - An owner therefore wins again only when it is the sole pending requester.
  - No bubble cycle: the next owner's first beat can occur in the cycle after the last beat.
- Beat: any OWNED cycle with req[o] high.
  - buf_wr_en = wr_en[o], buf_index = index slice o, buf_data_in = wdata slice o.
- Outside beats: buf_wr_en = 0, buf_index = 0, buf_data_in = 0. A non-owner's req never reaches the buffer.
- Read beat (wr_en[o] = 0): the next cycle gives rvalid = 1, rid = o, rdata = buf_data_out as it was during the beat.
- Write beat: rvalid = 0 next cycle.
- Watchdog:
  - The stall counter increments in each OWNED cycle with req[o] = 0.
  - It clears on every beat and on every ownership change.
  - When the counter reaches TIMEOUT, the next edge sets gnt = 0 (FREE) and pulses to_err for one cycle.
  - ptr becomes (o+1) mod NREQ.
- A single-beat burst is legal: req and last are high in the same cycle.

## Timing
- Reset (rst_n = 1 at an edge) forces:
  - gnt = 0, ptr = 0, stall counter = 0
  - rvalid = 0, rid = 0, rdata = 0, to_err = 0
- Reset mid-burst drops ownership immediately. An in-flight read produces no rvalid.
- Grant latency:
  - req rising in FREE at cycle t → gnt at t+1.
  - The first beat (ack) can occur at t+1.
- Read latency: exactly 1 cycle from the beat to rvalid. Back-to-back reads give rvalid high on consecutive cycles.
- Simultaneous events:
  - A watchdog expiry coinciding with a beat cannot occur, because a beat clears the counter.
  - Reset overrides everything.
- A requester dropping req mid-burst keeps ownership until it resumes or the watchdog fires.
- Throughput: one beat per cycle, including across handovers.

## Test plan
- Single writer: req[0] holds 4 beats writing rows 0..3 with data 0xA0..0xA3, last on beat 4.
  - Required: gnt = 001 one cycle after req.
  - Required: buf_wr_en high for exactly 4 cycles with the matching index and data, then gnt = 000.
- Contention: req = 111 asserted together from reset, each a 2-beat burst.
  - Required grant order: 0, 1, 2, with no idle cycle between bursts.
  - Then re-request req[0] and req[2] together → requester 0 wins (ptr = 0).
- Read tagging: requester 1 reads rows 5 and 6 back-to-back after those rows were preloaded.
  - Required: rvalid on the two following cycles, rid = 1, rdata equal to the preloaded words.
- Watchdog with TIMEOUT = 3: requester 2 stalls after its first beat.
  - Required: to_err pulses after 3 stalled cycles and gnt becomes 000.
  - Required: a pending req[0] is granted next.
- Isolation: requester 1 asserts req with wr_en while requester 0 owns the port.
  - Required: buf_wr_en follows requester 0 only; ack[1] = 0.
- Reset mid-burst: assert rst_n during requester 0's read beat.
  - Required: gnt = 000, rvalid = 0 next cycle.
  - Required: the first grant after reset goes to the lowest pending requester.
